// File: rtl/envio_uart_resposta.sv
// Two-byte UART response sender (8N1, LSB first): command byte then value byte,
// launched by a rising edge on dadosPodemSerEnviados.
module envio_uart_resposta #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dadosPodemSerEnviados,
    input  logic [7:0] response_command,
    input  logic [7:0] response_value,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic             byte_idx, byte_idx_nx;
    logic [7:0]       cmd_q, cmd_nx;
    logic [7:0]       val_q, val_nx;
    logic             tx_nx, busy_nx, done_nx, overrun_nx;
    logic             dados_prev_p0;
    logic             request;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign request  = dadosPodemSerEnviados & ~dados_prev_p0;
    assign bit_end  = (baud_cnt == CNT_LAST);
    assign cur_byte = byte_idx ? val_q : cmd_q;

    // tx is computed one cycle ahead so the line is driven straight from a flop.
    always_comb begin
        state_nx    = state;
        baud_cnt_nx = baud_cnt;
        bit_idx_nx  = bit_idx;
        byte_idx_nx = byte_idx;
        cmd_nx      = cmd_q;
        val_nx      = val_q;
        tx_nx       = tx;
        busy_nx     = busy;
        done_nx     = 1'b0;
        overrun_nx  = overrun;

        // The done cycle still belongs to the finished frame.
        if (request && (state != IDLE || done)) begin
            overrun_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                if (request && !done) begin
                    state_nx    = START;
                    byte_idx_nx = 1'b0;
                    baud_cnt_nx = '0;
                    cmd_nx      = response_command;
                    val_nx      = response_value;
                    tx_nx       = 1'b0;
                    busy_nx     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx    = DATA;
                    baud_cnt_nx = '0;
                    bit_idx_nx  = 3'd0;
                    tx_nx       = cur_byte[0];
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_nx = '0;
                    if (!byte_idx) begin
                        state_nx    = START;
                        byte_idx_nx = 1'b1;
                        tx_nx       = 1'b0;
                    end else begin
                        state_nx = IDLE;
                        tx_nx    = 1'b1;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= 3'd0;
            byte_idx      <= 1'b0;
            cmd_q         <= 8'd0;
            val_q         <= 8'd0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            // A level already high when reset releases must not count as an edge.
            dados_prev_p0 <= 1'b1;
        end else begin
            state         <= state_nx;
            baud_cnt      <= baud_cnt_nx;
            bit_idx       <= bit_idx_nx;
            byte_idx      <= byte_idx_nx;
            cmd_q         <= cmd_nx;
            val_q         <= val_nx;
            tx            <= tx_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            overrun       <= overrun_nx;
            dados_prev_p0 <= dadosPodemSerEnviados;
        end
    end

endmodule

// File: tb/tb_envio_uart_resposta.sv
// Scoreboard bench for envio_uart_resposta: a request model queues expected frames,
// a line monitor checks every bit period, the done cycle and reset behaviour.
module tb_envio_uart_resposta;

    localparam int CF    = 1000;
    localparam int BR    = 120;
    localparam int N     = CF / BR;   // 8 after truncation
    localparam int FRAME = 20 * N;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       din = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] val = 8'h00;
    logic       tx, busy, done, overrun;

    envio_uart_resposta #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .dadosPodemSerEnviados (din),
        .response_command      (cmd),
        .response_value        (val),
        .tx                    (tx),
        .busy                  (busy),
        .done                  (done),
        .overrun               (overrun)
    );

    always #5 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] c;
        logic [7:0] v;
        int         stamp;
    } exp_t;
    exp_t sb[$];

    int   m_busy = 0;
    logic m_prev = 1'b1;
    logic m_ovr  = 1'b0;
    bit   mon_in_frame = 1'b0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Request model: an accepted request blocks further requests until the cycle after done.
    initial begin
        logic req;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                m_busy = 0;
                m_prev = 1'b1;
                m_ovr  = 1'b0;
                sb.delete();
            end else begin
                req    = din & ~m_prev;
                m_prev = din;
                if (m_busy > 0) begin
                    if (req) m_ovr = 1'b1;
                    m_busy--;
                end else if (req) begin
                    sb.push_back('{c: cmd, v: val, stamp: cycle});
                    m_busy = FRAME + 1;
                end
            end
        end
    end

    // Line monitor.
    initial begin
        int   fc;
        int   ignore;
        bit   bit_ok;
        bit   bits [20];
        exp_t e;
        fc = 0;
        ignore = 0;
        bit_ok = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_in_frame = 1'b0;
                ignore = 0;
                check("reset_outputs", {28'd0, tx, busy, done, overrun}, 32'h8);
            end else if (ignore > 0) begin
                ignore--;
            end else begin
                if (!mon_in_frame) begin
                    if (tx == 1'b0) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_frame: tx went low with no accepted request (t=%0t)", $time);
                            ignore = FRAME;
                        end else begin
                            e = sb.pop_front();
                            check("start_latency", cycle, e.stamp + 1);
                            for (int i = 0; i < 8; i++) begin
                                bits[1 + i]  = ((e.c >> i) & 8'd1) != 0;
                                bits[11 + i] = ((e.v >> i) & 8'd1) != 0;
                            end
                            bits[0]  = 1'b0;
                            bits[9]  = 1'b1;
                            bits[10] = 1'b0;
                            bits[19] = 1'b1;
                            mon_in_frame = 1'b1;
                            fc = 0;
                            bit_ok = 1'b1;
                        end
                    end else begin
                        check("idle_done_low", {31'd0, done}, 32'd0);
                    end
                end
                if (mon_in_frame) begin
                    if (fc < FRAME) begin
                        if (tx !== bits[fc / N] || busy !== 1'b1 || done !== 1'b0) bit_ok = 1'b0;
                        if (fc % N == N - 1) begin
                            check($sformatf("bit%0d_cmd%02h_val%02h_level%0d_held", fc / N, e.c, e.v,
                                            bits[fc / N]), {31'd0, bit_ok}, 32'd1);
                            bit_ok = 1'b1;
                        end
                        fc++;
                    end else begin
                        check("done_cycle_tx_busy_done", {29'd0, tx, busy, done}, 32'h5);
                        mon_in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic request(logic [7:0] c, logic [7:0] v, int hold);
        cmd = c;
        val = v;
        din = 1'b1;
        tick(hold);
        din = 1'b0;
    endtask

    task automatic wait_idle(int limit);
        int k;
        k = 0;
        while ((busy || m_busy > 0 || mon_in_frame || sb.size() > 0) && k < limit) begin
            tick(1);
            k++;
        end
        if (k >= limit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b model_busy=%0d queued=%0d after %0d cycles",
                     busy, m_busy, sb.size(), k);
        end
    endtask

    initial begin
        int gap;
        reset_n = 1'b0;
        din = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("overrun_after_reset", {31'd0, overrun}, {31'd0, m_ovr});

        request(8'h09, 8'h1A, 1);
        wait_idle(FRAME + 20);
        check("overrun_basic", {31'd0, overrun}, {31'd0, m_ovr});

        request(8'h45, 8'h45, 3);
        wait_idle(FRAME + 20);
        check("overrun_held_high", {31'd0, overrun}, {31'd0, m_ovr});

        request(8'hA5, 8'h3C, 1);
        tick(100);
        request(8'h12, 8'h34, 1);
        check("overrun_set", {31'd0, overrun}, {31'd0, m_ovr});
        wait_idle(FRAME + 20);
        tick(30);
        check("overrun_sticky", {31'd0, overrun}, {31'd0, m_ovr});

        request(8'h5A, 8'hC3, 1);
        tick(13 * N + 2);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        check("overrun_cleared", {31'd0, overrun}, {31'd0, m_ovr});
        tick(FRAME + 10);
        request(8'h81, 8'h7E, 1);
        wait_idle(FRAME + 20);

        reset_n = 1'b0;
        din = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(FRAME);
        din = 1'b0;
        tick(2);
        request(8'hC6, 8'h29, 1);
        wait_idle(FRAME + 20);

        request(8'h33, 8'hCC, 1);
        tick(FRAME);
        din = 1'b1;
        tick(1);
        din = 1'b0;
        wait_idle(FRAME + 20);
        tick(5);
        check("overrun_done_cycle", {31'd0, overrun}, {31'd0, m_ovr});
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(2);

        request(8'h0F, 8'hF0, 1);
        wait_idle(FRAME + 20);
        request(8'hFF, 8'hFF, 1);
        wait_idle(FRAME + 20);

        for (int i = 0; i < 14; i++) begin
            request(8'($urandom), 8'($urandom), $urandom_range(1, 3));
            gap = $urandom_range(0, FRAME + 30);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 15) == 0) cmd = 8'($urandom);
                if ($urandom_range(0, 15) == 0) val = 8'($urandom);
                tick(1);
            end
            check($sformatf("overrun_random%0d", i), {31'd0, overrun}, {31'd0, m_ovr});
        end
        wait_idle(2 * FRAME + 40);
        tick(5);
        check("queue_empty_at_end", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/envio_uart_resposta.md
ENVIO_UART_RESPOSTA -- requirements
Module: envio_uart_resposta

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL derive CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer-truncated (5208 at defaults).
REQ-004 SHALL have port clock  input  1  system clock, 50 MHz; one clock domain only.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dadosPodemSerEnviados  input  1  response-ready level from the sensor-connection block; rising edge requests a transmission.
REQ-007 SHALL have port response_command  input  8  first byte to transmit.
REQ-008 SHALL have port response_value  input  8  second byte to transmit.
REQ-009 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-010 SHALL have port busy  output  1  high while a two-byte response is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the second stop bit completes.
REQ-012 SHALL have port overrun  output  1  sticky flag: a request arrived while busy.

Function
REQ-013 SHALL detect a request as dadosPodemSerEnviados high this cycle and low in the previous registered sample.
REQ-014 SHALL, on a request while idle, latch response_command and response_value in that same cycle; later input changes SHALL NOT affect the frame.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP; byte index (0 = command, 1 = value) SHALL select the latched byte.
REQ-016 IDLE: tx = 1, busy = 0; request -> START, byte index 0, baud counter 0, busy = 1 from the next cycle.
REQ-017 START: tx = 0 for exactly CLKS_PER_BIT cycles -> DATA, bit index 0.
REQ-018 DATA: tx = current bit, LSB first; each bit held exactly CLKS_PER_BIT cycles; after bit 7 -> STOP.
REQ-019 STOP: tx = 1 for exactly CLKS_PER_BIT cycles; if byte index 0 -> byte index 1, START with no idle gap; if byte index 1 -> IDLE and pulse done for one cycle.
REQ-020 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; bit index SHALL count 0..7.
REQ-021 tx SHALL go low the first cycle after the request cycle; full response SHALL last exactly 20 x CLKS_PER_BIT cycles (104160 at defaults) from first tx low to done.
REQ-022 A request while busy SHALL be ignored (no relatch, frame unaltered) and SHALL set overrun; overrun SHALL clear only on reset.
REQ-023 A request in the same cycle as done SHALL be treated as while busy (ignored, overrun set).
REQ-024 dadosPodemSerEnviados held high SHALL trigger only one transmission; a new one requires a low-then-high transition.
REQ-025 tx, busy, done, overrun SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-026 reset_n low SHALL immediately force tx = 1, busy = 0, done = 0, overrun = 0, state IDLE, counters and latched bytes 0.
REQ-027 Reset mid-frame SHALL abort the frame; no resumption after release.
REQ-028 Previous-sample register of dadosPodemSerEnviados SHALL reset to 1, so a level already high at reset release does not start a transmission.

Verification
REQ-029 command 0x09, value 0x1A, pulse request -> tx: 0,1,0,0,1,0,0,0,0,1 then 0,0,1,0,1,1,0,0,0,1, each bit 5208 cycles; done after 104160 cycles.
REQ-030 command 0x45, value 0x45, request held high 3 cycles -> exactly one two-byte frame, overrun stays 0.
REQ-031 second request 1000 cycles into a frame with different bytes -> original bytes sent unchanged, overrun = 1 until reset.
REQ-032 reset_n asserted during DATA of byte 1 -> tx = 1, busy = 0 within the reset cycle; no done pulse; next request sends a complete fresh frame.
REQ-033 dadosPodemSerEnviados high at reset release -> no transmission until it falls and rises again.
REQ-034 back-to-back: new request 1 cycle after done, command 0xFF, value 0xFF -> second frame starts with tx low next cycle, 1 bit period start then all ones.
